// File: rtl/i2s_pkg.sv
// Shared types and helpers for the I2S lane scheduler and related mixers.
package i2s_pkg;

   localparam int I2S_WIDTH = 24;

   typedef enum logic {CH_L = 1'b0, CH_R = 1'b1} chan_t;

   typedef enum logic {IDLE = 1'b0, SHOW = 1'b1} sched_state_t;

   function automatic int slot_idx(input chan_t chan, input int lane, input int lanes);
      return (chan == CH_R) ? lanes + lane : lane;
   endfunction

endpackage

// File: rtl/i2s_rr_pick.sv
// Combinational round-robin finder: first set request at or after i_base, wrapping modulo N.
module i2s_rr_pick #(
   parameter int N = 6,
   parameter int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0] i_req,
   input  logic [W-1:0] i_base,
   output logic [W-1:0] o_idx,
   output logic         o_found
);

   logic [W:0] w_cand;

   always_comb begin
      o_idx   = '0;
      o_found = 1'b0;
      w_cand  = '0;
      for (int k = 0; k < N; k++) begin
         w_cand = {1'b0, i_base} + (W+1)'(k);
         if (w_cand >= (W+1)'(N)) w_cand = w_cand - (W+1)'(N);
         if (!o_found && i_req[w_cand[W-1:0]]) begin
            o_found = 1'b1;
            o_idx   = w_cand[W-1:0];
         end
      end
   end

endmodule

// File: rtl/i2s_lane_sched.sv
// Buffers one sample per lane/channel slot and drains them round-robin onto a valid/ready stream.
// Optional lane_en masking is enabled by defining I2S_SCHED_LANE_MASK_EN.
//
//  state | meaning
//  IDLE  | nothing presented; load the next pending slot when one exists
//  SHOW  | sample held on out_*; on transfer load the next pending slot or return to IDLE
module i2s_lane_sched
   import i2s_pkg::*;
#(
   parameter int WIDTH  = I2S_WIDTH,
   parameter int LANES  = 3,
   parameter int SLOT_W = $clog2(2*LANES),
   localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic                   i2s_bclk,
   input  logic                   rst_n,
   input  logic [LANES*WIDTH-1:0] dataL_in,
   input  logic [LANES*WIDTH-1:0] dataR_in,
   input  logic [LANES-1:0]       detectL,
   input  logic [LANES-1:0]       detectR,
`ifdef I2S_SCHED_LANE_MASK_EN
   input  logic [LANES-1:0]       lane_en,
`endif
   output logic [WIDTH-1:0]       out_data,
   output logic [LANE_W-1:0]      out_lane,
   output logic                   out_chan,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [2*LANES-1:0]     overrun,
   input  logic                   ovr_clr,
   output logic [15:0]            frame_cnt
);

   localparam int NS = 2*LANES;

   sched_state_t      r_state;
   logic [WIDTH-1:0]  r_buf [NS];
   logic [NS-1:0]     r_pend;
   logic [NS-1:0]     r_ovr;
   logic [SLOT_W-1:0] r_ptr;
   logic [SLOT_W-1:0] r_slot;
   logic [WIDTH-1:0]  r_data;
   logic [LANE_W-1:0] r_lane;
   chan_t             r_chan;
   logic              r_valid;
   logic [15:0]       r_frame;

   logic [NS-1:0]     w_det;
   logic [NS-1:0]     w_en;
   logic [WIDTH-1:0]  w_sdata [NS];
   logic [NS-1:0]     w_req;
   logic [SLOT_W-1:0] w_base;
   logic [SLOT_W-1:0] w_nslot;
   logic [SLOT_W-1:0] w_pick;
   logic              w_found;
   logic              w_xfer;
   logic              w_load;
   logic [NS-1:0]     w_pick_oh;
   logic [NS-1:0]     w_pend_n;
   logic [NS-1:0]     w_ovr_n;
   chan_t             w_pchan;
   logic [LANE_W-1:0] w_plane;

   always_comb begin
      w_en = '1;
      for (int l = 0; l < LANES; l++) begin
`ifdef I2S_SCHED_LANE_MASK_EN
         w_en[slot_idx(CH_L, l, LANES)] = lane_en[l];
         w_en[slot_idx(CH_R, l, LANES)] = lane_en[l];
`endif
         w_sdata[slot_idx(CH_L, l, LANES)] = dataL_in[l*WIDTH +: WIDTH];
         w_sdata[slot_idx(CH_R, l, LANES)] = dataR_in[l*WIDTH +: WIDTH];
      end
      w_det = '0;
      for (int l = 0; l < LANES; l++) begin
         w_det[slot_idx(CH_L, l, LANES)] = detectL[l];
         w_det[slot_idx(CH_R, l, LANES)] = detectR[l];
      end
      w_det = w_det & w_en;
   end

   // In SHOW the pointer update is still in flight, so search from the slot after the presented one.
   assign w_nslot = (r_slot == SLOT_W'(NS-1)) ? '0 : r_slot + 1'b1;
   assign w_base  = (r_state == SHOW) ? w_nslot : r_ptr;
   assign w_req   = r_pend & w_en;

   i2s_rr_pick #(.N(NS), .W(SLOT_W)) u_pick (
      .i_req   (w_req),
      .i_base  (w_base),
      .o_idx   (w_pick),
      .o_found (w_found)
   );

   always_comb begin
      w_xfer    = (r_state == SHOW) && r_valid && out_ready;
      w_load    = w_found && ((r_state == IDLE) || w_xfer);
      w_pick_oh = '0;
      if (w_load) w_pick_oh[w_pick] = 1'b1;
      w_pend_n  = (w_req & ~w_pick_oh) | w_det;
      w_ovr_n   = (ovr_clr ? '0 : r_ovr) | (w_det & r_pend & ~w_pick_oh);
      w_pchan   = (int'(w_pick) >= LANES) ? CH_R : CH_L;
      w_plane   = LANE_W'((w_pchan == CH_R) ? int'(w_pick) - LANES : int'(w_pick));
   end

   always_ff @(posedge i2s_bclk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         for (int s = 0; s < NS; s++) r_buf[s] <= '0;
         r_pend  <= '0;
         r_ovr   <= '0;
         r_ptr   <= '0;
         r_slot  <= '0;
         r_data  <= '0;
         r_lane  <= '0;
         r_chan  <= CH_L;
         r_valid <= 1'b0;
         r_frame <= '0;
      end else begin
         for (int s = 0; s < NS; s++) begin
            if (w_det[s]) r_buf[s] <= w_sdata[s];
         end
         r_pend <= w_pend_n;
         r_ovr  <= w_ovr_n;
         if (w_xfer) r_ptr <= w_nslot;
         if (w_xfer && (r_slot == SLOT_W'(NS-1))) r_frame <= r_frame + 16'd1;
         case (r_state)
            IDLE: begin
               if (w_load) begin
                  r_data  <= r_buf[w_pick];
                  r_lane  <= w_plane;
                  r_chan  <= w_pchan;
                  r_slot  <= w_pick;
                  r_valid <= 1'b1;
                  r_state <= SHOW;
               end
            end
            SHOW: begin
               if (w_xfer) begin
                  if (w_load) begin
                     r_data <= r_buf[w_pick];
                     r_lane <= w_plane;
                     r_chan <= w_pchan;
                     r_slot <= w_pick;
                  end else begin
                     r_valid <= 1'b0;
                     r_state <= IDLE;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign out_data  = r_data;
   assign out_lane  = r_lane;
   assign out_chan  = r_chan;
   assign out_valid = r_valid;
   assign overrun   = r_ovr;
   assign frame_cnt = r_frame;

endmodule

// File: tb/tb_i2s_lane_sched.sv
// Directed vector bench for i2s_lane_sched (LANES=3, WIDTH=24).
module tb_i2s_lane_sched;

   logic        clk;
   logic        rst_n;
   logic [71:0] dataL_in, dataR_in;
   logic [2:0]  detectL, detectR, lane_en;
   logic [23:0] out_data;
   logic [1:0]  out_lane;
   logic        out_chan, out_valid, out_ready, ovr_clr;
   logic [5:0]  overrun;
   logic [15:0] frame_cnt;

   int nvec = 0;
   int nmis = 0;

   i2s_lane_sched #(.WIDTH(24), .LANES(3)) dut (
      .i2s_bclk  (clk),
      .rst_n     (rst_n),
      .dataL_in  (dataL_in),
      .dataR_in  (dataR_in),
      .detectL   (detectL),
      .detectR   (detectR),
`ifdef I2S_SCHED_LANE_MASK_EN
      .lane_en   (lane_en),
`endif
      .out_data  (out_data),
      .out_lane  (out_lane),
      .out_chan  (out_chan),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .overrun   (overrun),
      .ovr_clr   (ovr_clr),
      .frame_cnt (frame_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  dl, dr;
      logic [23:0] base;
      logic        rdy, clr;
      logic        ev;
      logic [23:0] ed;
      logic [1:0]  el;
      logic        ec;
      logic [5:0]  eo;
      logic [15:0] ef;
   } vec_t;

   vec_t q[$];

   function automatic vec_t mk(input logic [2:0] dl, dr, input logic [23:0] base,
                               input logic rdy, clr, ev, input logic [23:0] ed,
                               input logic [1:0] el, input logic ec,
                               input logic [5:0] eo, input logic [15:0] ef);
      vec_t v;
      v.dl = dl; v.dr = dr; v.base = base; v.rdy = rdy; v.clr = clr;
      v.ev = ev; v.ed = ed; v.el = el; v.ec = ec; v.eo = eo; v.ef = ef;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Lane k left = base + k*0x10, right = base + 0x100 + k*0x10.
   task automatic drive(input logic [2:0] dl, dr, input logic [23:0] base, input logic rdy, clr);
      for (int k = 0; k < 3; k++) begin
         dataL_in[k*24 +: 24] = base + 24'(k*16);
         dataR_in[k*24 +: 24] = base + 24'h100 + 24'(k*16);
      end
      detectL = dl; detectR = dr; out_ready = rdy; ovr_clr = clr;
   endtask

   initial begin
      rst_n = 1'b0; lane_en = 3'b111;
      drive(3'b000, 3'b000, 24'h0, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("reset valid", {31'd0, out_valid}, 32'd0);
      chk("reset data", {8'd0, out_data}, 32'd0);
      chk("reset ovr", {26'd0, overrun}, 32'd0);
      chk("reset frame", {16'd0, frame_cnt}, 32'd0);

      //              dl    dr    base       rdy  clr  ev   ed         el  ec  eo      ef
      q.push_back(mk(3'd7, 3'd7, 24'h100000, 1, 0, 0, 24'h0,      0, 0, 6'h00, 0));
      q.push_back(mk(3'd0, 3'd0, 24'h100000, 1, 0, 1, 24'h100000, 0, 0, 6'h00, 0));
      q.push_back(mk(3'd0, 3'd0, 24'h100000, 1, 0, 1, 24'h100010, 1, 0, 6'h00, 0));
      q.push_back(mk(3'd0, 3'd0, 24'h100000, 1, 0, 1, 24'h100020, 2, 0, 6'h00, 0));
      q.push_back(mk(3'd0, 3'd0, 24'h100000, 1, 0, 1, 24'h100100, 0, 1, 6'h00, 0));
      q.push_back(mk(3'd0, 3'd0, 24'h100000, 1, 0, 1, 24'h100110, 1, 1, 6'h00, 0));
      q.push_back(mk(3'd0, 3'd0, 24'h100000, 1, 0, 1, 24'h100120, 2, 1, 6'h00, 0));
      q.push_back(mk(3'd0, 3'd0, 24'h100000, 1, 0, 0, 24'h0,      0, 0, 6'h00, 1));
      // single sample on L1
      q.push_back(mk(3'd2, 3'd0, 24'h123446, 1, 0, 0, 24'h0,      0, 0, 6'h00, 1));
      q.push_back(mk(3'd0, 3'd0, 24'h123446, 1, 0, 1, 24'h123456, 1, 0, 6'h00, 1));
      q.push_back(mk(3'd0, 3'd0, 24'h123446, 1, 0, 0, 24'h0,      0, 0, 6'h00, 1));
      // R0 alone moves ptr to 4, then R1 and L0 together: R1 first
      q.push_back(mk(3'd0, 3'd1, 24'h200000, 1, 0, 0, 24'h0,      0, 0, 6'h00, 1));
      q.push_back(mk(3'd0, 3'd0, 24'h200000, 1, 0, 1, 24'h200100, 0, 1, 6'h00, 1));
      q.push_back(mk(3'd0, 3'd0, 24'h200000, 1, 0, 0, 24'h0,      0, 0, 6'h00, 1));
      q.push_back(mk(3'd1, 3'd2, 24'h300000, 1, 0, 0, 24'h0,      0, 0, 6'h00, 1));
      q.push_back(mk(3'd0, 3'd0, 24'h300000, 1, 0, 1, 24'h300110, 1, 1, 6'h00, 1));
      q.push_back(mk(3'd0, 3'd0, 24'h300000, 1, 0, 1, 24'h300000, 0, 0, 6'h00, 1));
      q.push_back(mk(3'd0, 3'd0, 24'h300000, 1, 0, 0, 24'h0,      0, 0, 6'h00, 1));
      // backpressure with L0 held, two more L0 detects -> overrun, newest wins
      q.push_back(mk(3'd1, 3'd0, 24'h400000, 0, 0, 0, 24'h0,      0, 0, 6'h00, 1));
      q.push_back(mk(3'd0, 3'd0, 24'h400000, 0, 0, 1, 24'h400000, 0, 0, 6'h00, 1));
      q.push_back(mk(3'd1, 3'd0, 24'hAAAAAA, 0, 0, 1, 24'h400000, 0, 0, 6'h00, 1));
      q.push_back(mk(3'd1, 3'd0, 24'h555555, 0, 0, 1, 24'h400000, 0, 0, 6'h01, 1));
      q.push_back(mk(3'd0, 3'd0, 24'h555555, 1, 0, 1, 24'h555555, 0, 0, 6'h01, 1));
      q.push_back(mk(3'd0, 3'd0, 24'h555555, 1, 0, 0, 24'h0,      0, 0, 6'h01, 1));
      q.push_back(mk(3'd0, 3'd0, 24'h555555, 1, 1, 0, 24'h0,      0, 0, 6'h00, 1));
      // detect on the same edge the slot is loaded: no overrun, old value shown
      q.push_back(mk(3'd1, 3'd0, 24'h600000, 0, 0, 0, 24'h0,      0, 0, 6'h00, 1));
      q.push_back(mk(3'd1, 3'd0, 24'h610000, 0, 0, 1, 24'h600000, 0, 0, 6'h00, 1));
      q.push_back(mk(3'd0, 3'd0, 24'h610000, 1, 0, 1, 24'h610000, 0, 0, 6'h00, 1));
      q.push_back(mk(3'd0, 3'd0, 24'h610000, 1, 0, 0, 24'h0,      0, 0, 6'h00, 1));
      // clear coincident with a new overrun: set wins
      q.push_back(mk(3'd1, 3'd0, 24'h700000, 0, 0, 0, 24'h0,      0, 0, 6'h00, 1));
      q.push_back(mk(3'd0, 3'd0, 24'h700000, 0, 0, 1, 24'h700000, 0, 0, 6'h00, 1));
      q.push_back(mk(3'd1, 3'd0, 24'h710000, 0, 0, 1, 24'h700000, 0, 0, 6'h00, 1));
      q.push_back(mk(3'd1, 3'd0, 24'h720000, 0, 1, 1, 24'h700000, 0, 0, 6'h01, 1));
      q.push_back(mk(3'd0, 3'd0, 24'h720000, 1, 0, 1, 24'h720000, 0, 0, 6'h01, 1));
      q.push_back(mk(3'd0, 3'd0, 24'h720000, 1, 0, 0, 24'h0,      0, 0, 6'h01, 1));
      q.push_back(mk(3'd0, 3'd0, 24'h720000, 1, 1, 0, 24'h0,      0, 0, 6'h00, 1));

      for (int i = 0; i < q.size(); i++) begin
         @(negedge clk);
         drive(q[i].dl, q[i].dr, q[i].base, q[i].rdy, q[i].clr);
         @(posedge clk);
         #1;
         chk($sformatf("row%0d valid", i), {31'd0, out_valid}, {31'd0, q[i].ev});
         if (q[i].ev) begin
            chk($sformatf("row%0d data", i), {8'd0, out_data}, {8'd0, q[i].ed});
            chk($sformatf("row%0d lane", i), {30'd0, out_lane}, {30'd0, q[i].el});
            chk($sformatf("row%0d chan", i), {31'd0, out_chan}, {31'd0, q[i].ec});
         end
         chk($sformatf("row%0d ovr", i), {26'd0, overrun}, {26'd0, q[i].eo});
         chk($sformatf("row%0d frame", i), {16'd0, frame_cnt}, {16'd0, q[i].ef});
      end

      // asynchronous reset while a sample is held
      @(negedge clk); drive(3'd1, 3'd0, 24'h900000, 1'b0, 1'b0);
      @(negedge clk); drive(3'd0, 3'd0, 24'h900000, 1'b0, 1'b0);
      @(posedge clk); #1;
      chk("pre-reset valid", {31'd0, out_valid}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async reset valid", {31'd0, out_valid}, 32'd0);
      chk("async reset data", {8'd0, out_data}, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      #1;
      chk("post-reset frame", {16'd0, frame_cnt}, 32'd0);
      chk("post-reset lane/chan", {29'd0, out_lane, out_chan}, 32'd0);
      @(negedge clk); drive(3'd0, 3'd4, 24'h800000, 1'b1, 1'b0);
      @(posedge clk); #1;
      chk("latency edge1 valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk); drive(3'd0, 3'd0, 24'h800000, 1'b1, 1'b0);
      @(posedge clk); #1;
      chk("latency edge2 valid", {31'd0, out_valid}, 32'd1);
      chk("latency data", {8'd0, out_data}, 32'h800120);
      chk("latency lane/chan", {29'd0, out_lane, out_chan}, 32'h5);
      @(posedge clk); #1;
      chk("R2 frame count", {16'd0, frame_cnt}, 32'd1);
      chk("R2 drained", {31'd0, out_valid}, 32'd0);

`ifdef I2S_SCHED_LANE_MASK_EN
      begin
         int nx = 0;
         int bad = 0;
         @(negedge clk); lane_en = 3'b101; drive(3'd7, 3'd7, 24'hC00000, 1'b1, 1'b0);
         @(negedge clk); drive(3'd0, 3'd0, 24'hC00000, 1'b1, 1'b0);
         for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (out_valid && out_ready) begin
               nx++;
               if (out_lane == 2'd1) bad++;
            end
         end
         chk("mask transfers", nx, 32'd4);
         chk("mask lane1 seen", bad, 32'd0);
         @(negedge clk); drive(3'd7, 3'd7, 24'hC00000, 1'b0, 1'b0);
         @(negedge clk); drive(3'd7, 3'd7, 24'hC00000, 1'b0, 1'b0);
         @(posedge clk); #1;
         chk("mask lane1 ovr", {30'd0, overrun[4], overrun[1]}, 32'd0);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
